hssl_router: RTL and testbench

//  Routing stage fed by hssl_reg_bank. Accepts 32-bit event packets on a valid/ready stream.

---
 rtl/hssl_pkg.sv | 12 +
 rtl/hssl_match_enc.sv | 36 +++
 rtl/hssl_router.sv | 112 +++++++++++
 tb/tb_hssl_router.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hssl_pkg.sv
// Shared types and constants for the HSSL routing stage.
package hssl_pkg;

    localparam int HSSL_PKT_W       = 32;
    localparam int HSSL_ROUTE_W     = 3;
    localparam int HSSL_NUM_ENTRIES = 16;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef logic [HSSL_PKT_W-1:0]   pkt_t;
    typedef logic [HSSL_ROUTE_W-1:0] route_t;

endpackage

// File: rtl/hssl_match_enc.sv
// Combinational key/mask table lookup; the lowest-index matching entry supplies the route.
module hssl_match_enc
    import hssl_pkg::*;
#(
    parameter int NUM_ENTRIES = HSSL_NUM_ENTRIES,
    parameter int PKT_W       = HSSL_PKT_W,
    parameter int ROUTE_W     = HSSL_ROUTE_W
) (
    input  logic [PKT_W-1:0]                      pkt,
    input  logic [NUM_ENTRIES-1:0][PKT_W-1:0]     key,
    input  logic [NUM_ENTRIES-1:0][PKT_W-1:0]     mask,
    input  logic [NUM_ENTRIES-1:0][ROUTE_W-1:0]   route,
    output logic                                  hit,
    output logic [ROUTE_W-1:0]                    hit_route
);

    logic [NUM_ENTRIES-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
            assign match[gi] = ((pkt & mask[gi]) == key[gi]);
        end
    endgenerate

    // Scanning from the top down lets the lowest matching index write last.
    always_comb begin
        hit       = |match;
        hit_route = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_route = route[i];
            end
        end
    end

endmodule

// File: rtl/hssl_router.sv
// Two-stage routing pipeline: table lookup in stage 1, forward/drop decision and output in stage 2.
module hssl_router
    import hssl_pkg::*;
#(
    parameter int NUM_ENTRIES = HSSL_NUM_ENTRIES,
    parameter int PKT_W       = HSSL_PKT_W,
    parameter int ROUTE_W     = HSSL_ROUTE_W
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [NUM_ENTRIES-1:0][PKT_W-1:0]     reg_key_in,
    input  logic [NUM_ENTRIES-1:0][PKT_W-1:0]     reg_mask_in,
    input  logic [NUM_ENTRIES-1:0][ROUTE_W-1:0]   reg_route_in,
    input  logic [PKT_W-1:0]                      pkt_data_in,
    input  logic                                  pkt_vld_in,
    output logic                                  pkt_rdy_out,
    output logic [PKT_W-1:0]                      pkt_data_out,
    output logic [ROUTE_W-1:0]                    pkt_route_out,
    output logic                                  pkt_vld_out,
    input  logic                                  pkt_rdy_in,
    input  logic                                  cnt_clr_in,
    output logic [31:0]                           drop_cnt_out,
    output logic [31:0]                           fwd_cnt_out
);

    logic               en;
    logic               accept;
    logic               enc_hit;
    logic [ROUTE_W-1:0] enc_route;

    logic               s1_vld_reg;
    logic [PKT_W-1:0]   s1_data_reg;
    logic               s1_hit_reg;
    logic [ROUTE_W-1:0] s1_route_reg;

    logic               vld_out_reg;
    logic [PKT_W-1:0]   data_out_reg;
    logic [ROUTE_W-1:0] route_out_reg;
    logic [31:0]        drop_cnt_reg;
    logic [31:0]        fwd_cnt_reg;

    logic               fwd;
    logic               drop;

    hssl_match_enc #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .PKT_W       (PKT_W),
        .ROUTE_W     (ROUTE_W)
    ) u_match_enc (
        .pkt       (pkt_data_in),
        .key       (reg_key_in),
        .mask      (reg_mask_in),
        .route     (reg_route_in),
        .hit       (enc_hit),
        .hit_route (enc_route)
    );

    // The whole pipeline advances together; a stalled output freezes both stages.
    assign en     = !vld_out_reg || pkt_rdy_in;
    assign accept = pkt_vld_in && en;
    assign fwd    = s1_vld_reg && s1_hit_reg && (s1_route_reg != '0);
    assign drop   = s1_vld_reg && !fwd;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_vld_reg    <= 1'b0;
            vld_out_reg   <= 1'b0;
            data_out_reg  <= '0;
            route_out_reg <= '0;
        end else if (en) begin
            s1_vld_reg  <= accept;
            vld_out_reg <= fwd;
            if (fwd) begin
                data_out_reg  <= s1_data_reg;
                route_out_reg <= s1_route_reg;
            end
        end
    end

    // Stage-1 payload is qualified by s1_vld_reg, so it needs no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_data_reg  <= pkt_data_in;
            s1_hit_reg   <= enc_hit;
            s1_route_reg <= enc_route;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || cnt_clr_in) begin
            drop_cnt_reg <= '0;
        end else if (en && drop && (drop_cnt_reg != CNT_MAX)) begin
            drop_cnt_reg <= drop_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || cnt_clr_in) begin
            fwd_cnt_reg <= '0;
        end else if (en && fwd && (fwd_cnt_reg != CNT_MAX)) begin
            fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
        end
    end

    assign pkt_rdy_out   = en;
    assign pkt_vld_out   = vld_out_reg;
    assign pkt_data_out  = data_out_reg;
    assign pkt_route_out = route_out_reg;
    assign drop_cnt_out  = drop_cnt_reg;
    assign fwd_cnt_out   = fwd_cnt_reg;

endmodule

// File: tb/tb_hssl_router.sv
// Self-checking bench for hssl_router: directed scenarios plus randomized traffic against a
// transaction-level reference model (table lookup on accept, expected-output queue, counters).
module tb_hssl_router;
    import hssl_pkg::*;

    localparam int NE = HSSL_NUM_ENTRIES;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [NE-1:0][31:0] reg_key;
    logic [NE-1:0][31:0] reg_mask;
    logic [NE-1:0][2:0]  reg_route;
    pkt_t        pkt_data_in;
    logic        pkt_vld_in;
    logic        pkt_rdy_out;
    pkt_t        pkt_data_out;
    route_t      pkt_route_out;
    logic        pkt_vld_out;
    logic        pkt_rdy_in;
    logic        cnt_clr_in;
    logic [31:0] drop_cnt_out;
    logic [31:0] fwd_cnt_out;

    hssl_router dut (
        .clk           (clk),
        .resetn        (resetn),
        .reg_key_in    (reg_key),
        .reg_mask_in   (reg_mask),
        .reg_route_in  (reg_route),
        .pkt_data_in   (pkt_data_in),
        .pkt_vld_in    (pkt_vld_in),
        .pkt_rdy_out   (pkt_rdy_out),
        .pkt_data_out  (pkt_data_out),
        .pkt_route_out (pkt_route_out),
        .pkt_vld_out   (pkt_vld_out),
        .pkt_rdy_in    (pkt_rdy_in),
        .cnt_clr_in    (cnt_clr_in),
        .drop_cnt_out  (drop_cnt_out),
        .fwd_cnt_out   (fwd_cnt_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference model state
    pkt_t        exp_q[$];
    route_t      exp_rq[$];
    logic [31:0] exp_drop = 0;
    logic [31:0] exp_fwd  = 0;
    logic        hold_prev = 1'b0;
    pkt_t        prev_data;
    route_t      prev_route;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Route 0 means drop, whether from no match or a zero-route match.
    function automatic int model_route(input pkt_t p);
        for (int i = 0; i < NE; i++)
            if ((p & reg_mask[i]) == reg_key[i]) return int'(reg_route[i]);
        return 0;
    endfunction

    always @(negedge clk) begin : monitor
        int r;
        check("rdy_rule", 32'(pkt_rdy_out), 32'(!pkt_vld_out || pkt_rdy_in));
        if (resetn) begin
            if (hold_prev) begin
                check("hold_vld", 32'(pkt_vld_out), 32'd1);
                check("hold_data", pkt_data_out, prev_data);
                check("hold_route", 32'(pkt_route_out), 32'(prev_route));
            end
            if (pkt_vld_out && pkt_rdy_in) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(pkt_vld_out), 32'd0);
                end else begin
                    check("out_data", pkt_data_out, exp_q[0]);
                    check("out_route", 32'(pkt_route_out), 32'(exp_rq[0]));
                    $display("OUT  data=0x%08h route=%03b", pkt_data_out, pkt_route_out);
                    void'(exp_q.pop_front());
                    void'(exp_rq.pop_front());
                end
            end
            if (pkt_vld_in && pkt_rdy_out) begin
                r = model_route(pkt_data_in);
                $display("IN   data=0x%08h exp_route=%03b", pkt_data_in, 3'(r));
                if (r == 0) begin
                    exp_drop = sat_inc(exp_drop);
                end else begin
                    exp_q.push_back(pkt_data_in);
                    exp_rq.push_back(route_t'(r));
                    exp_fwd = sat_inc(exp_fwd);
                end
            end
            hold_prev  = pkt_vld_out && !pkt_rdy_in;
            prev_data  = pkt_data_out;
            prev_route = pkt_route_out;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input pkt_t d);
        logic acc;
        int   b;
        pkt_vld_in  = 1'b1;
        pkt_data_in = d;
        b = 0;
        forever begin
            @(negedge clk);
            acc = pkt_rdy_out;
            tick();
            if (acc) break;
            b++;
            if (b > 50) begin
                check("send_timeout", 32'(pkt_rdy_out), 32'd1);
                break;
            end
        end
        pkt_vld_in = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        pkt_vld_in = 1'b0;
        while (exp_q.size() != 0 && b < 100) begin
            tick();
            b++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) tick();
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_drop"}, drop_cnt_out, exp_drop);
        check({tag, "_fwd"}, fwd_cnt_out, exp_fwd);
    endtask

    task automatic clear_table();
        for (int i = 0; i < NE; i++) begin
            reg_key[i]   = 32'h0;
            reg_mask[i]  = 32'hFFFF_FFFF;
            reg_route[i] = 3'b000;
        end
    endtask

    initial begin
        resetn      = 1'b0;
        pkt_vld_in  = 1'b0;
        pkt_data_in = '0;
        pkt_rdy_in  = 1'b1;
        cnt_clr_in  = 1'b0;
        clear_table();
        repeat (3) tick();
        check("rst_vld", 32'(pkt_vld_out), 32'd0);
        check("rst_data", pkt_data_out, 32'd0);
        check("rst_route", 32'(pkt_route_out), 32'd0);
        check_cnt("rst");
        resetn = 1'b1;
        tick();

        // 1: single match, exact two-cycle latency
        reg_key[0] = 32'h0000_1000; reg_mask[0] = 32'hFFFF_F000; reg_route[0] = 3'b001;
        pkt_vld_in = 1'b1; pkt_data_in = 32'h0000_1234;
        tick();
        pkt_vld_in = 1'b0;
        @(negedge clk);
        check("t1_lat1_vld", 32'(pkt_vld_out), 32'd0);
        tick();
        @(negedge clk);
        check("t1_lat2_vld", 32'(pkt_vld_out), 32'd1);
        check("t1_data", pkt_data_out, 32'h0000_1234);
        check("t1_route", 32'(pkt_route_out), 32'd1);
        tick();
        drain();
        check_cnt("t1");

        // 2: lowest index wins
        clear_table();
        reg_key[2] = 32'h0; reg_mask[2] = 32'h0; reg_route[2] = 3'b100;
        reg_key[5] = 32'hDEAD_BEEF; reg_route[5] = 3'b010;
        send(32'hDEAD_BEEF);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t2_route", 32'(pkt_route_out), 32'd4);
        drain();
        check_cnt("t2");

        // 3: no match, then zero-route match
        clear_table();
        for (int i = 0; i < NE; i++) begin
            reg_key[i] = 32'h100 + 32'(i); reg_route[i] = 3'b111;
        end
        for (int k = 0; k < 3; k++) send(32'hABCD_0000 + 32'(k));
        drain();
        check_cnt("t3a");
        reg_key[7] = 32'h1234_5678; reg_route[7] = 3'b000;
        send(32'h1234_5678);
        drain();
        check_cnt("t3b");

        // 4: back-to-back burst with output stall
        clear_table();
        reg_key[0] = 32'h0; reg_mask[0] = 32'h0; reg_route[0] = 3'b011;
        fork
            begin
                for (int k = 0; k < 8; k++) send(32'hC0DE_0000 + 32'(k));
            end
            begin
                pkt_rdy_in = 1'b1;
                repeat (3) tick();
                pkt_rdy_in = 1'b0;
                repeat (4) tick();
                pkt_rdy_in = 1'b1;
            end
        join
        drain();
        check_cnt("t4");

        // 5: saturation, then clear colliding with a drop
        clear_table();
        @(negedge clk);
        force dut.drop_cnt_reg = 32'hFFFF_FFFE;
        tick();
        release dut.drop_cnt_reg;
        exp_drop = 32'hFFFF_FFFE;
        send(32'h5555_0000);
        drain();
        check("t5_max", drop_cnt_out, 32'hFFFF_FFFF);
        send(32'h5555_0001);
        drain();
        check_cnt("t5_sat");
        pkt_vld_in = 1'b1; pkt_data_in = 32'h5555_0002;
        tick();
        pkt_vld_in = 1'b0;
        cnt_clr_in = 1'b1;
        tick();
        cnt_clr_in = 1'b0;
        exp_drop = 0;
        exp_fwd  = 0;
        drain();
        check_cnt("t5_clr");

        // 6: reset with packets in flight
        clear_table();
        reg_key[0] = 32'h0; reg_mask[0] = 32'h0; reg_route[0] = 3'b001;
        pkt_rdy_in = 1'b0;
        send(32'hF00D_0001);
        send(32'hF00D_0002);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        exp_q.delete();
        exp_rq.delete();
        exp_drop = 0;
        exp_fwd  = 0;
        @(negedge clk);
        check("t6_vld", 32'(pkt_vld_out), 32'd0);
        check_cnt("t6_rst");
        tick();
        pkt_rdy_in = 1'b1;
        send(32'hF00D_0003);
        drain();
        check_cnt("t6_after");

        // Randomized traffic
        for (int i = 0; i < NE; i++) begin
            case ($urandom_range(0, 3))
                0: reg_mask[i] = 32'hFFFF_FFFF;
                1: reg_mask[i] = 32'hFFFF_FF00;
                2: reg_mask[i] = 32'hFFFF_0000;
                default: reg_mask[i] = 32'hFF00_0000;
            endcase
            reg_key[i]   = $urandom & reg_mask[i];
            reg_route[i] = 3'($urandom_range(0, 7));
        end
        reg_mask[NE-1] = 32'h0;
        reg_key[NE-1]  = 32'h0;
        for (int c = 0; c < 600; c++) begin
            int e;
            e = $urandom_range(0, NE - 1);
            pkt_vld_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                pkt_data_in = reg_key[e] | ($urandom & ~reg_mask[e]);
            else
                pkt_data_in = $urandom;
            pkt_rdy_in = ($urandom_range(0, 3) != 0);
            tick();
        end
        pkt_rdy_in = 1'b1;
        drain();
        check_cnt("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
